// File: rtl/top_primitive.sv
// Two-stage saturating 4-bit multiply-accumulate: out1 = min(in1*in2 + in3, 2**W-1).
// Stage 1 registers the operands; stage 2 multiplies, adds, saturates and registers the result.
module top_primitive #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] out1
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned SW = 2 * W + 1;

    logic [W-1:0]  r1_q, r2_q, r3_q;
    logic [W-1:0]  out1_q, out1_d;
    logic [PW-1:0] pp [W];
    logic [PW-1:0] sum_lo, sum_hi, prod;
    logic [SW-1:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
        end else begin
            r1_q <= in1;
            r2_q <= in2;
            r3_q <= in3;
        end
    end

    // Shift-and-add array: row i is r2 gated by bit i of r1, weighted by 2**i.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            pp[i] = PW'({W{r1_q[i]}} & r2_q) << i;
        end
    end

    // Two-level tree: each half of the rows is summed, then the halves are combined.
    always_comb begin
        sum_lo = '0;
        sum_hi = '0;
        for (int i = 0; i < W; i++) begin
            if (i < W / 2) begin
                sum_lo = sum_lo + pp[i];
            end else begin
                sum_hi = sum_hi + pp[i];
            end
        end
        prod = sum_lo + sum_hi;
    end

    // Compare at full width so large products can never alias into the unsaturated range.
    always_comb begin
        sum    = SW'(prod) + SW'(r3_q);
        out1_d = (sum > SW'((1 << W) - 1)) ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1_q <= '0;
        end else begin
            out1_q <= out1_d;
        end
    end

    assign out1 = out1_q;

endmodule

// File: tb/tb_top_primitive.sv
// Scoreboard bench for top_primitive: directed vectors plus a full operand sweep,
// with expectations queued at issue time and checked by an independent monitor.
module tb_top_primitive;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in1 = 4'd0;
    logic [3:0] in2 = 4'd0;
    logic [3:0] in3 = 4'd0;
    logic [3:0] out1;

    logic       issue = 1'b0;
    logic [1:0] vld;
    logic [3:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    top_primitive #(.W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .out1 (out1)
    );

    initial forever #5 clk = ~clk;

    // Bench-side latency tracker: marks which edges should present a queued result.
    always @(posedge clk or posedge rst) begin
        if (rst) vld <= 2'b00;
        else     vld <= {vld[0], issue};
    end

    always @(negedge clk) begin
        if (!rst && vld[1]) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: out1=%0d with no expected value queued", out1);
            end else begin
                automatic logic [3:0] e = exp_q.pop_front();
                if (out1 !== e) begin
                    n_fail++;
                    $display("FAIL result @%0t: out1=%0d expected=%0d", $time, out1, e);
                end
            end
        end
    end

    function automatic logic [3:0] model(input int a, input int b, input int c);
        int s;
        s = a * b + c;
        return (s > 15) ? 4'd15 : 4'(s);
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] e);
        @(negedge clk);
        in1   = a;
        in2   = b;
        in3   = c;
        issue = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            issue = 1'b0;
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] req);
        n_checks++;
        if (out1 !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: out1=%0d expected=%0d", name, $time, out1, req);
        end
    endtask

    initial begin
        // Reset held with all-ones operands: output must stay cleared.
        in1 = 4'd15;
        in2 = 4'd15;
        in3 = 4'd15;
        #1 rst = 1'b1;
        #1 check_now("reset_async", 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_now("reset_hold", 4'd0);
        end
        rst = 1'b0;
        drive(4'd15, 4'd15, 4'd15, 4'd15);
        idle(3);

        // Non-saturating, isolated.
        drive(4'd3, 4'd4, 4'd2, 4'd14);
        idle(3);
        drive(4'd1, 4'd1, 4'd13, 4'd14);
        idle(3);
        drive(4'd0, 4'd9, 4'd5, 4'd5);
        idle(3);
        drive(4'd7, 4'd0, 4'd11, 4'd11);
        idle(3);

        // Saturation boundary.
        drive(4'd3, 4'd5, 4'd0, 4'd15);
        idle(3);
        drive(4'd4, 4'd4, 4'd0, 4'd15);
        idle(3);
        drive(4'd2, 4'd7, 4'd2, 4'd15);
        idle(3);
        drive(4'd1, 4'd2, 4'd14, 4'd15);
        idle(3);

        // Back-to-back sets.
        drive(4'd3, 4'd4, 4'd2, 4'd14);
        drive(4'd4, 4'd4, 4'd0, 4'd15);
        drive(4'd0, 4'd0, 4'd7, 4'd7);
        idle(3);

        // Mid-stream reset: (2,7,2) reaches out1, then reset kills (3,4,2) in flight.
        drive(4'd2, 4'd7, 4'd2, 4'd15);
        drive(4'd3, 4'd4, 4'd2, 4'd14);
        @(posedge clk);
        #1 check_now("pre_reset_out", 4'd15);
        #1;
        rst   = 1'b1;
        in1   = 4'd0;
        in2   = 4'd0;
        in3   = 4'd0;
        issue = 1'b0;
        exp_q.delete();
        #1 check_now("midreset_drop", 4'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_now("post_reset_zero", 4'd0);
        end

        // Full operand sweep, one set per clock.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 16; c++) begin
                    drive(4'(a), 4'(b), 4'(c), model(a, b, c));
                end
            end
        end
        idle(4);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
